// File: rtl/pipe_skid_buffer.sv
// Two-entry elastic pipeline stage with a skid register.
// Both handshake outputs decode from state flops only, so no input reaches an output combinationally.
module pipe_skid_buffer #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t       state_q, state_d;
  logic [N-1:0] main_q, main_d;
  logic [N-1:0] skid_q, skid_d;
  logic         in_fire, out_fire;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    // Flush only clears occupancy; stale data stays in the registers.
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_d  = in_data;
            state_d = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            skid_d  = in_data;
            state_d = TWO;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Bench for pipe_skid_buffer: directed vector table, async reset check, and
// randomized traffic against a queue-based occupancy model.
module tb_pipe_skid_buffer;
  localparam int N = 32;

  logic         clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [N-1:0] in_data, out_data;

  int n_cmp = 0;
  int n_err = 0;

  pipe_skid_buffer #(.N(N)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         fl;
    logic         iv;
    logic [N-1:0] d;
    logic         ordy;
    logic         e_ov;
    logic         e_ir;
    logic [N-1:0] e_od;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic fl, input logic iv, input logic [N-1:0] d, input logic ordy,
                     input logic e_ov, input logic e_ir, input logic [N-1:0] e_od);
    vec_t v;
    v.fl = fl; v.iv = iv; v.d = d; v.ordy = ordy;
    v.e_ov = e_ov; v.e_ir = e_ir; v.e_od = e_od;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
    rst = 1;
    #3;
    rst = 0;
    tick();
  endtask

  // Reference: a bounded FIFO of depth 2 holding words in arrival order.
  logic [N-1:0] mq[$];
  logic [N-1:0] last_out;

  initial begin
    rst = 0; flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
    #2;
    do_reset();
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready",  {31'd0, in_ready},  32'd1);
    chk("reset_out_data",  out_data, 32'd0);

    //   fl iv data         ordy  ov ir out_data
    // streaming
    add(0, 1, 32'h10, 1,   1, 1, 32'h10);
    add(0, 1, 32'h14, 1,   1, 1, 32'h14);
    add(0, 1, 32'h18, 1,   1, 1, 32'h18);
    add(0, 0, 32'h00, 1,   0, 1, 32'h18);
    // backpressure and skid
    add(0, 1, 32'h11, 0,   1, 1, 32'h11);
    add(0, 1, 32'h22, 0,   1, 0, 32'h11);
    add(0, 1, 32'h33, 0,   1, 0, 32'h11);
    add(0, 1, 32'h33, 1,   1, 1, 32'h22);
    add(0, 1, 32'h33, 0,   1, 0, 32'h22);
    add(0, 0, 32'h00, 1,   1, 1, 32'h33);
    add(0, 0, 32'h00, 1,   0, 1, 32'h33);
    // flush from TWO, then next push
    add(0, 1, 32'h44, 0,   1, 1, 32'h44);
    add(0, 1, 32'h55, 0,   1, 0, 32'h44);
    add(1, 1, 32'h66, 0,   0, 1, 32'h44);
    add(0, 1, 32'h77, 0,   1, 1, 32'h77);
    add(0, 0, 32'h00, 1,   0, 1, 32'h77);
    // flush from ONE drops an accepted word and leaves main untouched
    add(0, 1, 32'hA0, 0,   1, 1, 32'hA0);
    add(1, 1, 32'hA1, 0,   0, 1, 32'hA0);
    add(0, 0, 32'h00, 0,   0, 1, 32'hA0);
    // simultaneous read/write in ONE
    add(0, 1, 32'h88, 0,   1, 1, 32'h88);
    add(0, 1, 32'h99, 1,   1, 1, 32'h99);
    add(0, 0, 32'h00, 0,   1, 1, 32'h99);
    add(0, 0, 32'h00, 1,   0, 1, 32'h99);
    // out_ready pulse while empty
    add(0, 0, 32'h00, 1,   0, 1, 32'h99);

    foreach (vecs[i]) begin
      flush = vecs[i].fl; in_valid = vecs[i].iv; in_data = vecs[i].d; out_ready = vecs[i].ordy;
      tick();
      chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
      chk($sformatf("vec%0d_in_ready", i),  {31'd0, in_ready},  {31'd0, vecs[i].e_ir});
      chk($sformatf("vec%0d_out_data", i),  out_data, vecs[i].e_od);
    end

    // asynchronous reset while holding two words
    flush = 0; out_ready = 0;
    in_valid = 1; in_data = 32'hAAAA_0001; tick();
    in_data = 32'hAAAA_0002; tick();
    in_valid = 0;
    chk("pre_rst_in_ready", {31'd0, in_ready}, 32'd0);
    #3;
    rst = 1;
    #1;
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("async_rst_out_data",  out_data, 32'd0);
    #1;
    rst = 0;
    tick();
    chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

    // randomized traffic against the FIFO model
    mq.delete();
    last_out = '0;
    for (int c = 0; c < 1000; c++) begin
      logic       ifire, ofire;
      logic [N-1:0] prev_od;
      logic       prev_hold;
      flush     = ($urandom_range(0, 49) == 0);
      in_valid  = ($urandom_range(0, 99) < 65);
      out_ready = ($urandom_range(0, 99) < 60);
      in_data   = $urandom;
      ifire = in_valid && (mq.size() < 2);
      ofire = out_ready && (mq.size() > 0);
      prev_hold = out_valid && !out_ready && !flush;
      prev_od   = out_data;
      tick();
      if (flush) begin
        mq.delete();
      end else begin
        if (ofire) void'(mq.pop_front());
        if (ifire) mq.push_back(in_data);
      end
      chk("rnd_out_valid", {31'd0, out_valid}, {31'd0, (mq.size() > 0)});
      chk("rnd_in_ready",  {31'd0, in_ready},  {31'd0, (mq.size() < 2)});
      if (mq.size() > 0) chk("rnd_out_data", out_data, mq[0]);
      if (prev_hold) chk("rnd_stable_data", out_data, prev_od);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
